// File: rtl/bsg_bypass_reg_rr_ctrl_pkg.sv
// Shared helpers for the round-robin bypass register controller.
package bsg_bypass_reg_rr_ctrl_pkg;

   // Pointer width that never collapses to zero bits, even for a single requester.
   function automatic int safe_clog2(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/bsg_bypass_reg_rr_ctrl_dff_en_bypass.sv
// Holding register with load enable; the enable also steers the incoming word straight to the output.
module bsg_dff_en_bypass #(
   parameter int width_p = 128
) (
   input  logic               clk_i,
   input  logic               en_i,
   input  logic [width_p-1:0] data_i,
   output logic [width_p-1:0] data_o
);

   logic [width_p-1:0] data_r;

   always_ff @(posedge clk_i) begin
      if (en_i)
         data_r <= data_i;
   end

   assign data_o = en_i ? data_i : data_r;

endmodule

// File: rtl/bsg_bypass_reg_rr_ctrl.sv
// Round-robin arbiter sharing one enable/bypass holding register among els_p producers.
module bsg_bypass_reg_rr_ctrl
   import bsg_bypass_reg_rr_ctrl_pkg::*;
#(
   parameter int width_p = 128,
   parameter int els_p   = 4
) (
   input  logic                     clk_i,
   input  logic                     reset_i,
   input  logic [els_p-1:0]         v_i,
   input  logic [els_p*width_p-1:0] data_i,
   output logic [els_p-1:0]         yumi_o,
   output logic                     v_o,
   output logic [width_p-1:0]       data_o,
   input  logic                     yumi_i
);

   localparam int ptr_w_lp = safe_clog2(els_p);

   logic                  full_r;
   logic [ptr_w_lp-1:0]   ptr_r;
   logic                  grant_v;
   logic [ptr_w_lp-1:0]   winner;
   logic [2*els_p-1:0]    v_dbl;
   logic [2*els_p-1:0]    v_rot;
   logic                  found;
   int                    win_idx;
   logic [width_p-1:0]    winner_data;

   // Rotate so the priority requester lands at bit 0, then take the first set bit.
   assign v_dbl = {v_i, v_i};
   assign v_rot = v_dbl >> ptr_r;

   always_comb begin
      found   = 1'b0;
      win_idx = 0;
      winner  = '0;
      for (int k = 0; k < els_p; k++) begin
         if (!found && v_rot[k]) begin
            found   = 1'b1;
            win_idx = int'(ptr_r) + k;
            if (win_idx >= els_p)
               win_idx = win_idx - els_p;
         end
      end
      winner = ptr_w_lp'(win_idx);
   end

   // Grants never look at yumi_i, keeping yumi_i off every output path.
   assign grant_v = ~reset_i & ~full_r & (|v_i);

   always_comb begin
      for (int i = 0; i < els_p; i++)
         yumi_o[i] = grant_v && (winner == ptr_w_lp'(i));
   end

   always_comb begin
      winner_data = '0;
      for (int i = 0; i < els_p; i++)
         winner_data = winner_data | (data_i[i*width_p +: width_p] & {width_p{yumi_o[i]}});
   end

   bsg_dff_en_bypass #(.width_p(width_p)) hold_reg (
      .clk_i  (clk_i),
      .en_i   (grant_v),
      .data_i (winner_data),
      .data_o (data_o)
   );

   assign v_o = ~reset_i & (full_r | grant_v);

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         full_r <= 1'b0;
         ptr_r  <= '0;
      end else begin
         full_r <= (full_r | grant_v) & ~yumi_i;
         if (grant_v)
            ptr_r <= (winner == ptr_w_lp'(els_p-1)) ? '0 : winner + 1'b1;
      end
   end

   a_yumi_needs_valid: assert property (@(posedge clk_i) disable iff (reset_i) !(yumi_i && !v_o))
      else $error("yumi_i asserted while v_o is low");

endmodule

// File: tb/tb_bsg_bypass_reg_rr_ctrl.sv
// Vector table plus randomized run against a behavioural model of the round-robin bypass register.
module tb_bsg_bypass_reg_rr_ctrl;

   localparam int W = 128;
   localparam int N = 4;

   logic           clk_i = 1'b0;
   logic           reset_i = 1'b1;
   logic [N-1:0]   v_i = '0;
   logic [N*W-1:0] data_i = '0;
   logic [N-1:0]   yumi_o;
   logic           v_o;
   logic [W-1:0]   data_o;
   logic           yumi_i = 1'b0;

   int vectors_applied = 0;
   int miscompares = 0;

   bsg_bypass_reg_rr_ctrl #(.width_p(W), .els_p(N)) dut (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .v_i     (v_i),
      .data_i  (data_i),
      .yumi_o  (yumi_o),
      .v_o     (v_o),
      .data_o  (data_o),
      .yumi_i  (yumi_i)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic         rst;
      logic [N-1:0] v;
      logic         y;
      logic [119:0] base;
      logic [N-1:0] ey;
      logic         ev;
      logic [W-1:0] ed;
   } vec_t;

   vec_t tbl[$];

   function automatic logic [W-1:0] slot(input int s, input logic [119:0] base);
      return {8'(s), base};
   endfunction

   function automatic vec_t mkv(input logic rst, input logic [N-1:0] v, input logic y,
                                input logic [119:0] base, input logic [N-1:0] ey,
                                input logic ev, input logic [W-1:0] ed);
      vec_t t;
      t.rst = rst; t.v = v; t.y = y; t.base = base; t.ey = ey; t.ev = ev; t.ed = ed;
      return t;
   endfunction

   task automatic check(input string name, input int idx, input logic [W-1:0] act,
                        input logic [W-1:0] exp);
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, exp);
      end
   endtask

   // Behavioural model: occupancy, priority index and held word.
   logic         m_full;
   int           m_ptr;
   logic [W-1:0] m_data;

   task automatic model_step(input logic rst, input logic [N-1:0] v, input logic y,
                             input logic [W-1:0] d [N],
                             output logic [N-1:0] ey, output logic ev, output logic [W-1:0] ed);
      int  w;
      logic grant;
      ey = '0; ev = 1'b0; ed = m_data;
      if (rst) begin
         m_full = 1'b0;
         m_ptr  = 0;
         return;
      end
      grant = !m_full && (v != 0);
      w = -1;
      for (int k = 0; k < N; k++)
         if (w < 0 && v[(m_ptr + k) % N]) w = (m_ptr + k) % N;
      ev = m_full || grant;
      if (grant) begin
         ey[w] = 1'b1;
         ed = d[w];
         m_ptr = (w + 1) % N;
         if (!y) begin
            m_full = 1'b1;
            m_data = d[w];
         end
      end else if (m_full && y) begin
         m_full = 1'b0;
      end
   endtask

   initial begin
      logic [W-1:0] d [N];
      logic [N-1:0] ey;
      logic         ev;
      logic [W-1:0] ed;
      logic [N-1:0] rv;
      logic         ry, rr;

      // Reset behaviour
      tbl.push_back(mkv(1, 4'h0, 0, 120'h0,   4'b0000, 0, '0));
      tbl.push_back(mkv(1, 4'hF, 1, 120'h0,   4'b0000, 0, '0));
      tbl.push_back(mkv(0, 4'h0, 0, 120'h0,   4'b0000, 0, '0));
      // Bypass with same-cycle consume, then wrap/skip cases
      tbl.push_back(mkv(0, 4'b0100, 1, 120'hA5, 4'b0100, 1, slot(2, 120'hA5)));
      tbl.push_back(mkv(0, 4'b0010, 1, 120'h22, 4'b0010, 1, slot(1, 120'h22)));
      tbl.push_back(mkv(0, 4'b0100, 1, 120'h2a, 4'b0100, 1, slot(2, 120'h2a)));
      tbl.push_back(mkv(0, 4'b1000, 1, 120'h33, 4'b1000, 1, slot(3, 120'h33)));
      // Hold: no grants while full, one bubble after drain
      tbl.push_back(mkv(0, 4'b0001, 0, 120'h11, 4'b0001, 1, slot(0, 120'h11)));
      tbl.push_back(mkv(0, 4'hF,    0, 120'h44, 4'b0000, 1, slot(0, 120'h11)));
      tbl.push_back(mkv(0, 4'hF,    0, 120'h55, 4'b0000, 1, slot(0, 120'h11)));
      tbl.push_back(mkv(0, 4'hF,    1, 120'h66, 4'b0000, 1, slot(0, 120'h11)));
      tbl.push_back(mkv(0, 4'hF,    1, 120'h77, 4'b0010, 1, slot(1, 120'h77)));
      // Fairness from reset
      tbl.push_back(mkv(1, 4'hF, 1, 120'h0, 4'b0000, 0, '0));
      for (int k = 0; k < 8; k++)
         tbl.push_back(mkv(0, 4'hF, 1, 120'(k + 'h100), 4'(1 << (k % 4)), 1,
                           slot(k % 4, 120'(k + 'h100))));
      // Reset while full discards held word and pointer
      tbl.push_back(mkv(0, 4'b0001, 0, 120'hBEEF, 4'b0001, 1, slot(0, 120'hBEEF)));
      tbl.push_back(mkv(0, 4'b0000, 0, 120'h0,    4'b0000, 1, slot(0, 120'hBEEF)));
      tbl.push_back(mkv(1, 4'b0000, 0, 120'h0,    4'b0000, 0, '0));
      tbl.push_back(mkv(0, 4'b0000, 0, 120'h0,    4'b0000, 0, '0));
      tbl.push_back(mkv(0, 4'b0011, 1, 120'h88,   4'b0001, 1, slot(0, 120'h88)));
      tbl.push_back(mkv(0, 4'b0010, 1, 120'h99,   4'b0010, 1, slot(1, 120'h99)));

      foreach (tbl[i]) begin
         @(negedge clk_i);
         reset_i = tbl[i].rst;
         v_i     = tbl[i].v;
         yumi_i  = tbl[i].y;
         for (int s = 0; s < N; s++) data_i[s*W +: W] = slot(s, tbl[i].base);
         #4;
         vectors_applied++;
         check("tbl_yumi_o", i, W'(yumi_o), W'(tbl[i].ey));
         check("tbl_v_o",    i, W'(v_o),    W'(tbl[i].ev));
         if (tbl[i].ev) check("tbl_data_o", i, data_o, tbl[i].ed);
      end

      // Randomized run; starts with a reset so the model and DUT agree.
      m_full = 1'b0; m_ptr = 0; m_data = '0;
      for (int i = 0; i < 3000; i++) begin
         rr = (i == 0) || ($urandom_range(0, 99) == 0);
         rv = 4'($urandom);
         if ($urandom_range(0, 3) == 0) rv = '0;
         for (int s = 0; s < N; s++) d[s] = {$urandom, $urandom, $urandom, $urandom};
         // Decide yumi only when the model says the output is valid, keeping stimulus legal.
         begin
            logic f_save; int p_save; logic [W-1:0] h_save;
            f_save = m_full; p_save = m_ptr; h_save = m_data;
            model_step(rr, rv, 1'b0, d, ey, ev, ed);
            m_full = f_save; m_ptr = p_save; m_data = h_save;
         end
         ry = ev && ($urandom_range(0, 2) != 0);
         model_step(rr, rv, ry, d, ey, ev, ed);
         @(negedge clk_i);
         reset_i = rr;
         v_i     = rv;
         yumi_i  = ry;
         for (int s = 0; s < N; s++) data_i[s*W +: W] = d[s];
         #4;
         vectors_applied++;
         check("rnd_yumi_o", i, W'(yumi_o), W'(ey));
         check("rnd_v_o",    i, W'(v_o),    W'(ev));
         if (ev) check("rnd_data_o", i, data_o, ed);
      end

      @(negedge clk_i);
      yumi_i = 1'b0;
      v_i = '0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
      $finish;
   end

endmodule
